// File: rtl/rbr_pkg.sv
// rbr_pkg: shared types for the redundant-binary (radix-2 signed-digit) datapath.
//   signed_digit  : one MSDF quotient digit encoded as {plus, minus}
//   otf_state_t   : state encoding of the on-the-fly converter
//   sd_to_int()   : decodes a signed_digit to its value -1, 0 or +1
package rbr_pkg;

  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } otf_state_t;

  // Both 00 and 11 mean zero; only a lone plus or a lone minus carries weight.
  function automatic logic signed [1:0] sd_to_int(input signed_digit d);
    logic signed [1:0] val;
    case ({d.plus, d.minus})
      2'b10:   val = 2'sd1;
      2'b01:   val = -2'sd1;
      default: val = 2'sd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/otf_append_cell.sv
// otf_append_cell: one combinational on-the-fly conversion step.
// Appends a signed digit to the Q/QM register pair (QM is always Q-1), so no
// carry propagation is ever needed.
//   q, qm            : current converted value and its predecessor
//   digit            : incoming signed digit
//   q_next, qm_next  : values after appending the digit (shifted left by one)
module otf_append_cell
  import rbr_pkg::*;
#(
  parameter int W = 13
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  signed_digit  digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic signed [1:0] d_val;

  // A negative digit borrows from QM, a positive one turns Q into the new QM,
  // and a zero digit simply extends both.
  always_comb begin
    d_val   = sd_to_int(digit);
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    if (d_val == 2'sd1) begin
      q_next  = {q[W-2:0], 1'b1};
      qm_next = {q[W-2:0], 1'b0};
    end else if (d_val == -2'sd1) begin
      q_next  = {qm[W-2:0], 1'b1};
      qm_next = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/online_otf_converter.sv
// online_otf_converter: turns an MSDF radix-2 signed-digit quotient stream into
// a two's-complement fraction, one digit per accepted beat, and offers the
// finished operand through a valid/ready handshake.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : digit beat valid
//   in_ready    : converter can accept a digit (low while a result waits)
//   in_first    : beat carries the most significant digit of an operand
//   in_digit    : signed digit {plus, minus}
//   out_valid   : out_result holds a finished operand
//   out_ready   : downstream takes the result
//   out_result  : value = out_result * 2^-N_DIGITS
//   busy        : an operand is partially converted
module online_otf_converter
  import rbr_pkg::*;
#(
  parameter int N_DIGITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  signed_digit         in_digit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_DIGITS:0]   out_result,
  output logic                busy
);

  localparam int W     = N_DIGITS + 1;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);
  localparam bit IS_SINGLE = (N_DIGITS == 1);

  otf_state_t state, state_next;

  logic [W-1:0]     q_reg, qm_reg;
  logic [W-1:0]     q_base, qm_base;
  logic [W-1:0]     q_next, qm_next;
  logic [CNT_W-1:0] cnt;

  logic accept, load_first, extend, last_digit, out_fire;

  assign accept     = in_valid && in_ready;
  assign load_first = accept && in_first;
  assign extend     = accept && !in_first && (state == ACCUM);
  assign last_digit = (load_first && IS_SINGLE) || (extend && (cnt == CNT_LAST));
  assign out_fire   = out_valid && out_ready;

  // A first digit (also one that aborts an operand) updates the freshly
  // loaded Q=0 / QM=-1 pair instead of the registers.
  assign q_base  = load_first ? '0 : q_reg;
  assign qm_base = load_first ? '1 : qm_reg;

  otf_append_cell #(.W(W)) u_append (
    .q       (q_base),
    .qm      (qm_base),
    .digit   (in_digit),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (last_digit)      state_next = DONE;
        else if (load_first) state_next = ACCUM;
      end
      DONE: begin
        if (out_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    in_ready = (state != DONE);
    busy     = (state == ACCUM);
  end

  // Datapath: conversion registers, digit counter and result holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg      <= '0;
      qm_reg     <= '1;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      if (load_first || extend) begin
        q_reg  <= q_next;
        qm_reg <= qm_next;
      end
      if (last_digit)      cnt <= '0;
      else if (load_first) cnt <= CNT_W'(1);
      else if (extend)     cnt <= cnt + CNT_W'(1);
      if (last_digit) begin
        out_result <= q_next;
        out_valid  <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// tb_online_otf_converter: directed and randomised checks of the on-the-fly
// converter with N_DIGITS=4. Expected results are queued when an operand is
// driven and compared when the converter hands a result downstream.
module tb_online_otf_converter;
  import rbr_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_first = 1'b0;
  signed_digit    in_digit = '0;
  logic           out_valid;
  logic           out_ready;
  logic [N:0]     out_result;
  logic           busy;

  logic           rand_mode = 1'b0;
  logic           fixed_ready = 1'b1;
  logic           rnd_ready = 1'b1;

  int compared = 0;
  int mismatched = 0;
  logic [N:0] sb[$];

  assign out_ready = rand_mode ? rnd_ready : fixed_ready;

  online_otf_converter #(.N_DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .in_digit   (in_digit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Random downstream readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference value of four digits: sum of q_i * 2^(4-i), as 5-bit two's complement.
  function automatic logic [N:0] model_value(input logic [1:0] d0, input logic [1:0] d1,
                                             input logic [1:0] d2, input logic [1:0] d3);
    int acc;
    logic [1:0] ds[4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (ds[i] == 2'b10)      acc += (1 << (3 - i));
      else if (ds[i] == 2'b01) acc -= (1 << (3 - i));
    end
    return (N+1)'(acc);
  endfunction

  // Present one beat and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic apply_stimulus(input logic first, input logic [1:0] dig);
    int cycles;
    in_valid = 1'b1;
    in_first = first;
    in_digit = signed_digit'(dig);
    cycles = 0;
    while (!in_ready && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!in_ready) check_output("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_operand(input logic [1:0] d0, input logic [1:0] d1,
                              input logic [1:0] d2, input logic [1:0] d3, input bit gaps);
    logic [1:0] ds[4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    sb.push_back(model_value(d0, d1, d2, d3));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i == 0, ds[i]);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare each result as it is handed downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check_output("unexpected_result", 32'(sb.size()), 32'd1);
      else check_output("result", 32'(out_result), 32'(sb.pop_front()));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_out_result", 32'(out_result), 32'd0);
    check_output("reset_q", 32'(dut.q_reg), 32'd0);
    check_output("reset_qm", 32'(dut.qm_reg), 32'h1f);

    // +1,0,-1,+1 -> 7/16, valid on the 4th accept edge
    sb.push_back(5'b00111);
    apply_stimulus(1'b1, 2'b10);
    check_output("busy_after_first", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 2'b00);
    apply_stimulus(1'b0, 2'b01);
    check_output("no_valid_before_last", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, 2'b10);
    check_output("valid_on_last_edge", 32'(out_valid), 32'd1);
    check_output("busy_in_done", 32'(busy), 32'd0);
    wait_drain();

    send_operand(2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
    send_operand(2'b10, 2'b01, 2'b01, 2'b01, 1'b0);
    send_operand(2'b01, 2'b10, 2'b10, 2'b10, 1'b0);
    send_operand(2'b11, 2'b11, 2'b11, 2'b10, 1'b0);
    wait_drain();

    // Backpressure
    fixed_ready = 1'b0;
    send_operand(2'b10, 2'b10, 2'b10, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_out_result", 32'(out_result), 32'h0f);
      @(posedge clk); #1;
    end
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_release_out_valid", 32'(out_valid), 32'd0);
    check_output("bp_release_in_ready", 32'(in_ready), 32'd1);
    send_operand(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    wait_drain();

    // Restart: aborted operand produces nothing
    apply_stimulus(1'b1, 2'b00);
    apply_stimulus(1'b0, 2'b10);
    send_operand(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    wait_drain();

    // Non-first digit in IDLE is dropped
    apply_stimulus(1'b0, 2'b10);
    check_output("idle_drop_busy", 32'(busy), 32'd0);
    check_output("idle_drop_q", 32'(dut.q_reg), 32'h18);
    send_operand(2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
    wait_drain();

    // Reset mid-operand
    apply_stimulus(1'b1, 2'b10);
    apply_stimulus(1'b0, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_q", 32'(dut.q_reg), 32'd0);
    check_output("midrst_qm", 32'(dut.qm_reg), 32'h1f);
    rst = 1'b0;
    send_operand(2'b01, 2'b10, 2'b00, 2'b10, 1'b0);
    wait_drain();

    // Randomised operands with gaps and random out_ready
    rand_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send_operand(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
    end
    wait_drain();
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/online_otf_converter.md
Name: online_otf_converter

Overview:
Receive-side companion to the online divider stage. Consumes the MSDF radix-2 signed-digit quotient stream (rbr_pkg::signed_digit) one digit per accepted beat and converts it on the fly into a conventional two's-complement fraction, using Q/QM register pairs. Sits at the divider array output. Presents the completed result through a valid/ready handshake to downstream logic.

Parameters:
N_DIGITS, 12, number of signed digits per operand; result width is N_DIGITS+1.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  digit beat valid
in_ready  output  1  converter can accept a digit
in_first  input  1  marks the first (most significant) digit of an operand
in_digit  input  signed_digit  quotient digit {plus,minus}
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  N_DIGITS+1  two's-complement result, value = out_result * 2^-N_DIGITS
busy  output  1  high in ACCUM

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Digit decode: {plus,minus} = 10 -> +1; 01 -> -1; 00 or 11 -> 0.
- Registers: Q and QM, each N_DIGITS+1 bits; digit counter cnt, 0..N_DIGITS-1; state.
- States are IDLE, ACCUM and DONE.
  - Reset: state=IDLE, Q=0, QM=all ones, cnt=0, out_valid=0, out_result=0, busy=0.
- Accept: a beat is accepted when in_valid && in_ready.
  - in_ready = (state != DONE).
- IDLE behaviour:
  - Accepted beat with in_first=1: load Q=0 and QM=-1, then apply the digit update. Set cnt=1 and go to ACCUM.
  - Accepted beat with in_first=0: discard it; state unchanged.
  - If N_DIGITS==1, go directly to DONE.
- Digit update (on the current Q/QM, or the freshly loaded values):
  - q=+1: Q <= {Q,1}; QM <= {Q,0}.
  - q=0: Q <= {Q,0}; QM <= {QM,1}.
  - q=-1: Q <= {QM,1}; QM <= {QM,0}.
  - Each update shifts left by one, dropping the MSB. Width is sufficient because |value| <= 2^N_DIGITS - 1.
  - Invariant: QM = Q - 1 after each update.
- ACCUM behaviour:
  - Accepted beat with in_first=0: apply the update and increment cnt.
  - When the accepted digit is digit N_DIGITS (cnt==N_DIGITS-1): out_result <= next Q, out_valid <= 1, cnt <= 0, state <= DONE.
  - Accepted beat with in_first=1: abandon the current operand, reload Q=0 and QM=-1, apply the digit, set cnt=1. No output is produced.
- DONE behaviour:
  - out_result is stable and out_valid=1 until out_valid && out_ready.
  - On that handshake: out_valid <= 0, state <= IDLE.
  - in_ready is 0 throughout DONE; a first digit presented in the handshake cycle is taken on the next cycle.
- Latency: out_valid rises on the clock edge that accepts the last digit. Minimum operand period is N_DIGITS+1 cycles.
- Gaps: in_valid=0 in ACCUM holds all state; there is no timeout.
- busy = (state == ACCUM).
- Reset mid-operation returns every register to its reset value on the next edge; any partial result is lost.

Decomposition:
- rbr_pkg: add function sd_to_int(signed_digit) returning 2-bit signed {-1,0,+1}. Add enum otf_state_t {IDLE, ACCUM, DONE}.
- One sub-module is natural: otf_append_cell. It is combinational, takes (Q, QM, digit) and returns (Q_next, QM_next). The divider-array wrapper reuses it for an unpipelined converter.
- The counter and FSM stay in the top module.

Test Plan:
All scenarios use N_DIGITS=4.
- Digits +1,0,-1,+1 with in_first on beat 1 -> out_valid on the 4th accept edge; out_result=5'b00111 (7/16).
- Digits -1,-1,-1,-1 -> out_result=5'b10001 (-15/16). Digits +1,+1,+1,+1 -> 5'b01111.
- Digits -1,+1,+1,+1 -> out_result=5'b11111 (-1/16). Encodings 11 and 00 are both zero: 11,11,11,10 -> 5'b00001.
- Backpressure: hold out_ready=0 for 5 cycles after done.
  - Required: in_ready=0 and out_result stable throughout.
  - Raise out_ready: out_valid falls next edge and in_ready rises.
  - A following operand +1,0,0,0 -> 5'b01000.
- Restart and reset:
  - Beats 0 (first),+1, then in_first with -1,0,0,0 -> single result 5'b11000; no result from the aborted operand.
  - Digit without in_first in IDLE is dropped.
  - rst asserted after 2 digits: next edge busy=0, out_valid=0, Q=0, QM=5'b11111.
- Randomised: random digits with random in_valid/out_ready gaps -> out_result equals the sum of q_i*2^(4-i) for every operand. Scoreboard against this formula.
